// File: rtl/pipe_stage_reg_pkg.sv
// Shared encodings for pipeline stage registers: stall/reset polarity, NOP payload, stage modes.
package pipe_stage_reg_pkg;

  localparam logic RstEnable = 1'b1;
  localparam logic Stop      = 1'b1;
  localparam logic NoStop    = 1'b0;
  localparam logic NopBit    = 1'b0;
  localparam int   STALL_W   = 6;

  typedef enum logic [2:0] {
    MODE_RESET,
    MODE_FLUSH,
    MODE_BUBBLE,
    MODE_HOLD,
    MODE_LOAD
  } mode_e;

  typedef struct packed {
    logic valid;
    logic delayslot;
  } ctl_t;

  // Own stage stopped with the next stage running means a bubble must be pushed downstream.
  function automatic mode_e decode_mode(input logic rst, input logic flush,
                                        input logic own_stall, input logic next_stall);
    if (rst == RstEnable)    return MODE_RESET;
    if (flush)               return MODE_FLUSH;
    if (own_stall == Stop)   return (next_stall == NoStop) ? MODE_BUBBLE : MODE_HOLD;
    return MODE_LOAD;
  endfunction

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating event counter; sticks at all-ones instead of wrapping.
module sat_counter
  import pipe_stage_reg_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst == RstEnable)
      count <= '0;
    else if (inc && (count != {CNT_W{1'b1}}))
      count <= count + 1'b1;
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with reset/flush/bubble/hold/load priority and stall perf counters.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter int               STAGE    = 2,
  parameter logic [WIDTH-1:0] NOP_WORD = {WIDTH{NopBit}},
  parameter int               CNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic [WIDTH-1:0]   in_data,
  input  logic               in_valid,
  input  logic               in_next_delayslot,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  output logic               out_delayslot,
  output logic [CNT_W-1:0]   bubble_cnt,
  output logic [CNT_W-1:0]   hold_cnt
);

  mode_e mode;
  ctl_t  ctl_q;
  logic  unused_stall;

  assign mode         = decode_mode(rst, flush, stall[STAGE], stall[STAGE+1]);
  assign unused_stall = ^stall;

  always_ff @(posedge clk) begin
    case (mode)
      MODE_RESET, MODE_FLUSH: begin
        out_data <= NOP_WORD;
        ctl_q    <= '{valid: 1'b0, delayslot: 1'b0};
      end
      MODE_BUBBLE: begin
        // Delay-slot flag belongs to the instruction still held upstream, so keep it.
        out_data    <= NOP_WORD;
        ctl_q.valid <= 1'b0;
      end
      MODE_HOLD: ;
      default: begin
        out_data <= in_valid ? in_data : NOP_WORD;
        ctl_q    <= '{valid: in_valid, delayslot: in_next_delayslot};
      end
    endcase
  end

  assign out_valid     = ctl_q.valid;
  assign out_delayslot = ctl_q.delayslot;

  sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (mode == MODE_BUBBLE),
    .count (bubble_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_hold_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (mode == MODE_HOLD),
    .count (hold_cnt)
  );

endmodule
